// File: rtl/qsys_cpu_ocimem_sched.sv
// OCI RAM port scheduler: arbitrates JTAG debug commands against CPU debug-mode
// accesses on one synchronous RAM port. Optional: QSYS_CPU_OCIMEM_AUTOINC_EN.
module qsys_cpu_ocimem_sched #(
  parameter int RAM_AW     = 8,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, J_ISSUE, J_RDATA, C_ISSUE, C_RDATA} state_t;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] mon_addr_q, mon_addr_d, slot_addr_q, slot_addr_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              slot_v_q, slot_v_d, slot_we_q, slot_we_d, op_we_q, op_we_d;
  logic [31:0]       mondreg_q, mondreg_d, ram_wdata_q, ram_wdata_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              ready_q, ready_d, err_q, err_d, gnt_q, gnt_d;
  logic              rvalid_q, rvalid_d, ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              strobe, jbusy, acc, drop, j_pend, j_we, cpu_wins, done;
  logic [RAM_AW-1:0] eff_addr, j_addr;
  logic [31:0]       j_wdata;

  always_comb begin
    strobe   = take_action_ocimem_b || take_no_action_ocimem_a;
    jbusy    = slot_v_q || (state_q == J_ISSUE) || (state_q == J_RDATA);
    acc      = strobe && debugack && !jbusy;
    drop     = strobe && !acc;
    // An address load in the same cycle as a command steers that command.
    eff_addr = take_action_ocimem_a ? jdo[26 +: RAM_AW] : mon_addr_q;
    // A freshly accepted strobe bypasses the slot so an idle machine issues next cycle.
    j_pend   = slot_v_q || acc;
    j_we     = acc ? take_action_ocimem_b : slot_we_q;
    j_addr   = acc ? eff_addr : slot_addr_q;
    j_wdata  = acc ? jdo[34:3] : mondreg_q;
    cpu_wins = cpu_req && (!j_pend || (starve_q == SMAX));
    done     = ((state_q == J_ISSUE) && op_we_q) || (state_q == J_RDATA);

    state_d     = state_q;
    mon_addr_d  = mon_addr_q;
    slot_v_d    = slot_v_q;
    slot_we_d   = slot_we_q;
    slot_addr_d = slot_addr_q;
    op_we_d     = op_we_q;
    mondreg_d   = mondreg_q;
    ready_d     = ready_q;
    err_d       = err_q;
    cpu_rdata_d = cpu_rdata_q;
    gnt_d       = 1'b0;
    rvalid_d    = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    starve_d    = cpu_req ? starve_q : '0;

    if (done) begin
      ready_d = 1'b1;
`ifdef QSYS_CPU_OCIMEM_AUTOINC_EN
      mon_addr_d = mon_addr_q + 1'b1;
`endif
    end
    if (take_action_ocimem_a) begin
      mon_addr_d = jdo[26 +: RAM_AW];
      if (jdo[25]) err_d = 1'b0;
    end
    if (drop) err_d = 1'b1;
    if (acc) begin
      ready_d     = 1'b0;
      slot_v_d    = 1'b1;
      slot_we_d   = take_action_ocimem_b;
      slot_addr_d = eff_addr;
      if (take_action_ocimem_b) mondreg_d = jdo[34:3];
    end

    case (state_q)
      IDLE: begin
        if (cpu_wins) begin
          state_d     = C_ISSUE;
          gnt_d       = 1'b1;
          ram_en_d    = 1'b1;
          ram_we_d    = cpu_we;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_we ? cpu_wdata : '0;
          op_we_d     = cpu_we;
          starve_d    = '0;
        end else if (j_pend) begin
          state_d     = J_ISSUE;
          ram_en_d    = 1'b1;
          ram_we_d    = j_we;
          ram_addr_d  = j_addr;
          ram_wdata_d = j_we ? j_wdata : '0;
          op_we_d     = j_we;
          slot_v_d    = 1'b0;
          if (cpu_req && (starve_q != SMAX)) starve_d = starve_q + 1'b1;
        end
      end
      J_ISSUE: state_d = op_we_q ? IDLE : J_RDATA;
      J_RDATA: begin
        mondreg_d = ram_rdata;
        state_d   = IDLE;
      end
      C_ISSUE: state_d = op_we_q ? IDLE : C_RDATA;
      C_RDATA: begin
        cpu_rdata_d = ram_rdata;
        rvalid_d    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mon_addr_q  <= '0;
      slot_v_q    <= 1'b0;
      slot_we_q   <= 1'b0;
      slot_addr_q <= '0;
      op_we_q     <= 1'b0;
      mondreg_q   <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      gnt_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mon_addr_q  <= mon_addr_d;
      slot_v_q    <= slot_v_d;
      slot_we_q   <= slot_we_d;
      slot_addr_q <= slot_addr_d;
      op_we_q     <= op_we_d;
      mondreg_q   <= mondreg_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      starve_q    <= starve_d;
    end
  end

  assign cpu_gnt       = gnt_q;
  assign cpu_rvalid    = rvalid_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign MonDReg       = mondreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;
endmodule

// File: doc/qsys_cpu_ocimem_sched.md
# qsys_cpu_ocimem_sched

Scheduler for the Nios II on-chip debug memory (OCI RAM, 256 x 32) shared between the JTAG debug host and the CPU's debug-mode load/store port. It consumes the single-cycle `take_action_ocimem_*` strobes and the `jdo` payload from the JTAG debug wrapper (system-clock side), arbitrates them against CPU requests onto one synchronous RAM port, and returns `MonDReg`, `monitor_ready` and `monitor_error` back to the wrapper. It sits in the CPU debug subsystem between the JTAG debug wrapper, the CPU OCI slave port and the OCI RAM instance.

## Interface
- `RAM_AW`, 8: OCI RAM word-address width.
- `STARVE_MAX`, 2: consecutive JTAG grants allowed while the CPU is waiting.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; one clock, reset is synchronous and active-low
- `jdo`  in  38  JTAG payload: addr = `jdo[33:26]`, wdata = `jdo[34:3]`
- `take_action_ocimem_a`  in  1  load address strobe
- `take_action_ocimem_b`  in  1  JTAG write strobe
- `take_no_action_ocimem_a`  in  1  JTAG read strobe
- `debugack`  in  1  CPU is in debug mode
- `cpu_req`, `cpu_we`  in  1  CPU access request / write enable
- `cpu_addr`  in  RAM_AW  CPU word address
- `cpu_wdata`  in  32  CPU write data
- `cpu_gnt`  out  1  CPU request accepted this cycle
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  32  CPU read data
- `ram_en`, `ram_we`  out  1  RAM port enable / write
- `ram_addr`  out  RAM_AW  RAM address
- `ram_wdata`  out  32  RAM write data
- `ram_rdata`  in  32  RAM read data, valid one cycle after `ram_en && !ram_we`
- `MonDReg`  out  32  monitor data register
- `monitor_ready`  out  1  last JTAG command completed
- `monitor_error`  out  1  sticky JTAG protocol error

## Operation
- `mon_addr` (RAM_AW bits) loaded from `jdo[33:26]` on `take_action_ocimem_a`; no RAM access.
- JTAG write strobe: `MonDReg <= jdo[34:3]`, pending op = WR at `mon_addr`.
- JTAG read strobe: pending op = RD at `mon_addr`.
- One-deep JTAG pending slot. Strobe arriving while the slot is occupied or an op is in flight: dropped, `monitor_error <= 1`.
- Strobe with `debugack == 0`: dropped, `monitor_error <= 1`. `monitor_error` clears only on reset or on `take_action_ocimem_a` with `jdo[25] == 1`.
- Accepted WR/RD strobe clears `monitor_ready` the next cycle; completion sets it.
- FSM states: IDLE, J_ISSUE, J_RDATA, C_ISSUE, C_RDATA.
  - IDLE: grant by priority; JTAG first unless `starve_cnt == STARVE_MAX` and `cpu_req`, in which case CPU.
  - J_ISSUE: drive RAM one cycle; WR -> IDLE (complete), RD -> J_RDATA.
  - J_RDATA: `MonDReg <= ram_rdata`, complete -> IDLE.
  - C_ISSUE: `cpu_gnt` pulses on entry cycle; write -> IDLE, read -> C_RDATA.
  - C_RDATA: `cpu_rdata <= ram_rdata`, `cpu_rvalid` 1 cycle -> IDLE.
- `starve_cnt` increments on each JTAG grant while `cpu_req` is high, saturates at STARVE_MAX, clears on CPU grant or when `cpu_req` is low.
- Simultaneous address-load and read/write strobe: the load takes effect first; the op uses the new address.

## Timing
- Reset values: `MonDReg` 0, `monitor_ready` 1, `monitor_error` 0, `cpu_gnt` 0, `cpu_rvalid` 0, `cpu_rdata` 0, `ram_en`/`ram_we` 0, `ram_addr`/`ram_wdata` 0, FSM IDLE, slot empty, `mon_addr` 0.
- Reset mid-operation aborts the access. No RAM write issues after the reset cycle.
- JTAG write, idle machine, strobe at cycle N: `ram_en=ram_we=1` at N+1, `monitor_ready=1` at N+2.
- JTAG read, strobe at N: `ram_en=1` at N+1, `MonDReg` valid and `monitor_ready=1` at N+3.
- CPU read granted at N (`cpu_gnt`): `ram_en` at N, `cpu_rvalid` at N+2. CPU write completes at N.
- Minimum spacing between back-to-back JTAG commands: 3 cycles for read, 2 for write. All outputs are registered.

## Configuration
- `QSYS_CPU_OCIMEM_AUTOINC_EN` defined: `mon_addr` increments by 1, wrapping 255 -> 0, on completion of every JTAG read or write.
- Not defined: `mon_addr` changes only on `take_action_ocimem_a`.

## Test plan
- Load addr 0x10, write 0xDEADBEEF, load 0x10, read -> `ram_we` at addr 0x10 with data 0xDEADBEEF; `MonDReg=0xDEADBEEF` and `monitor_ready=1` three cycles after the read strobe.
- With AUTOINC: load 0xFF, write A, write B -> RAM writes at 0xFF then 0x00. Without AUTOINC: both writes go to 0xFF.
- Second write strobe one cycle after the first -> second dropped, `monitor_error=1`; cleared by address-load with `jdo[25]=1`.
- `cpu_req` held high plus continuous JTAG writes, `STARVE_MAX=2` -> grants follow J, J, C, J, J, C; CPU read returns stored data with `cpu_rvalid` two cycles after `cpu_gnt`.
- Read strobe with `debugack=0` -> no `ram_en`, `monitor_error=1`, `monitor_ready` unchanged.
- `reset_n` low for one cycle during J_RDATA -> `MonDReg=0`, `monitor_ready=1`, FSM IDLE, no stale `cpu_rvalid`.
